// File: rtl/pkg_en.sv
// Shared token types, widths and responder FSM states for the external memory
// responder and its RAM.
package pkg_en;

  localparam int WIDTH_DATA   = 32;
  localparam int WIDTH_EXADDR = 12;

  // Forward token: valid, first-of-stream, two reserved flags, index, data
  typedef struct packed {
    logic                    v;
    logic                    a;
    logic                    r;
    logic                    c;
    logic [WIDTH_EXADDR-1:0] i;
    logic [WIDTH_DATA-1:0]   d;
  } FTk_t;

  // Back token: n = nack/stall, e = reserved
  typedef struct packed {
    logic n;
    logic e;
  } BTk_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_BOOT_HDR  = 2'd1,
    ST_BOOT_PROG = 2'd2,
    ST_SERVE     = 2'd3
  } state_e;

  function automatic FTk_t ftk_make(input logic v, input logic a,
                                    input logic [WIDTH_EXADDR-1:0] i,
                                    input logic [WIDTH_DATA-1:0] d);
    ftk_make = '{v: v, a: a, r: 1'b0, c: 1'b0, i: i, d: d};
  endfunction

endpackage

// File: rtl/ext_mem_ram.sv
// Single-read, single-write RAM with a synchronous, enable-gated read register
// (read-before-write on address collision).
module ext_mem_ram #(
  parameter int DEPTH = 1024,
  parameter int DW    = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          i_rd_en,
  input  logic [AW-1:0] i_rd_addr,
  output logic [DW-1:0] o_rd_data,
  input  logic          i_we,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [DW-1:0] i_wr_data
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_q;

  // Memory write and held read register; contents deliberately not reset
  always_ff @(posedge clock) begin
    if (i_we) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    if (i_rd_en) begin
      r_q <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_q;

endmodule

// File: rtl/ext_mem_responder.sv
// External memory responder: boot stream (header + program words), then 1-cycle
// load serving; stores and host preload write any time. Option: EXTEND_MEM_EN.
module ext_mem_responder
  import pkg_en::*;
#(
  parameter int DEPTH    = 1024,
  parameter int BOOT_HDR = 3,
  parameter int BOOT_LEN = 5
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    I_Boot,
  input  logic                    I_Ld_Req,
  input  logic [WIDTH_EXADDR-1:0] I_Ld_Addr,
  output FTk_t                    O_Ld_FTk,
  input  BTk_t                    I_Ld_BTk,
  input  logic                    I_St_Req,
  input  logic [WIDTH_EXADDR-1:0] I_St_Addr,
  input  FTk_t                    I_St_FTk,
  output BTk_t                    O_St_BTk,
  input  logic                    I_Host_We,
  input  logic [WIDTH_EXADDR-1:0] I_Host_Addr,
  input  logic [WIDTH_DATA-1:0]   I_Host_Data
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = 16;

  state_e                  r_state;
  logic [CW-1:0]           r_cnt;
  logic                    r_v;
  logic                    r_a;
  logic                    r_dsel;
  logic                    w_boot_go;
  logic                    w_boot_adv;
  logic                    w_seq;
  logic                    w_serve_smp;
  logic [CW-1:0]           w_nidx;
  logic [CW-1:0]           w_boot_k;
  logic                    w_is_hdr;
  logic                    w_is_prog;
  logic                    w_rd_en;
  logic [AW-1:0]           w_rd_addr;
  logic [WIDTH_DATA-1:0]   w_rd_data;
  logic                    w_we;
  logic [AW-1:0]           w_wr_addr;
  logic [WIDTH_DATA-1:0]   w_wr_data;
  logic [WIDTH_EXADDR-1:0] w_i;
  logic                    w_unused;

  // A boot (re)start, or a boot word accepted downstream, moves to the next stream index
  assign w_boot_go   = I_Boot & ((r_state == ST_IDLE) | (r_state == ST_SERVE));
  assign w_boot_adv  = ((r_state == ST_BOOT_HDR) | (r_state == ST_BOOT_PROG)) & ~I_Ld_BTk.n;
  assign w_seq       = w_boot_go | w_boot_adv;
  assign w_serve_smp = (r_state == ST_SERVE) & ~I_Boot & ~I_Ld_BTk.n;
  assign w_nidx      = w_boot_go ? {CW{1'b0}} : (r_cnt + CW'(1));
  assign w_boot_k    = w_nidx - CW'(BOOT_HDR);
  assign w_is_hdr    = (w_nidx < CW'(BOOT_HDR));
  assign w_is_prog   = ~w_is_hdr & (w_nidx < CW'(BOOT_HDR + BOOT_LEN));

  // RAM read port: program word during boot, requested address while serving
  always_comb begin
    w_rd_en   = 1'b0;
    w_rd_addr = {AW{1'b0}};
    if (w_seq) begin
      w_rd_en   = w_is_prog;
      w_rd_addr = w_boot_k[AW-1:0];
    end else if (w_serve_smp) begin
      w_rd_en   = I_Ld_Req;
      w_rd_addr = I_Ld_Addr[AW-1:0];
    end else begin
      w_rd_en   = 1'b0;
      w_rd_addr = {AW{1'b0}};
    end
  end

  // RAM write port: host preload wins, and the store is then refused
  always_comb begin
    w_we      = 1'b0;
    w_wr_addr = {AW{1'b0}};
    w_wr_data = {WIDTH_DATA{1'b0}};
    if (I_Host_We) begin
      w_we      = 1'b1;
      w_wr_addr = I_Host_Addr[AW-1:0];
      w_wr_data = I_Host_Data;
    end else begin
      w_we      = I_St_Req & I_St_FTk.v;
      w_wr_addr = I_St_Addr[AW-1:0];
      w_wr_data = I_St_FTk.d;
    end
  end

  ext_mem_ram #(
    .DEPTH (DEPTH),
    .DW    (WIDTH_DATA),
    .AW    (AW)
  ) u_ram (
    .clock     (clock),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data),
    .i_we      (w_we),
    .i_wr_addr (w_wr_addr),
    .i_wr_data (w_wr_data)
  );

  // Responder FSM and load-token flags; a stalled token simply keeps its registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= {CW{1'b0}};
      r_v     <= 1'b0;
      r_a     <= 1'b0;
      r_dsel  <= 1'b0;
    end else if (w_seq) begin
      r_cnt  <= w_nidx;
      r_v    <= w_is_hdr | w_is_prog;
      r_a    <= w_is_hdr & (w_nidx == {CW{1'b0}});
      r_dsel <= w_is_prog;
      if (w_is_hdr) begin
        r_state <= ST_BOOT_HDR;
      end else if (w_is_prog) begin
        r_state <= ST_BOOT_PROG;
      end else begin
        r_state <= ST_SERVE;
      end
    end else if (w_serve_smp) begin
      r_v    <= I_Ld_Req;
      r_a    <= 1'b0;
      r_dsel <= I_Ld_Req;
    end
  end

`ifdef EXTEND_MEM_EN
  logic [WIDTH_EXADDR-1:0] r_i;

  // Index compression: serve tokens carry their load address, boot tokens zero
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_i <= {WIDTH_EXADDR{1'b0}};
    end else if (w_seq) begin
      r_i <= {WIDTH_EXADDR{1'b0}};
    end else if (w_serve_smp) begin
      r_i <= I_Ld_Addr;
    end
  end

  assign w_i = r_i;
`else
  assign w_i = {WIDTH_EXADDR{1'b0}};
`endif

  assign O_Ld_FTk = ftk_make(r_v, r_a, w_i, r_dsel ? w_rd_data : {WIDTH_DATA{1'b0}});
  assign O_St_BTk = '{n: I_Host_We, e: 1'b0};

  assign w_unused = ^{I_Ld_BTk.e, I_Ld_Addr, I_St_Addr, I_Host_Addr,
                      I_St_FTk.a, I_St_FTk.r, I_St_FTk.c, I_St_FTk.i};

endmodule

// File: doc/ext_mem_responder.md
EXT_MEM_RESPONDER -- requirements
Module: ext_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, meaning memory words (power of two); address = low log2(DEPTH) bits of WIDTH_EXADDR input, wraps modulo DEPTH.
REQ-002 SHALL have parameter BOOT_HDR, default 3, meaning zero header words emitted before program words.
REQ-003 SHALL have parameter BOOT_LEN, default 5, meaning program words emitted from mem[0..BOOT_LEN-1].
REQ-004 SHALL have one clock; reset is asynchronous and active-low.
REQ-005 clock  input  1  rising-edge clock.
REQ-006 reset  input  1  asynchronous active-low reset.
REQ-007 I_Boot  input  1  boot start request, level-sampled.
REQ-008 I_Ld_Req  input  1  load request from array.
REQ-009 I_Ld_Addr  input  WIDTH_EXADDR  load address.
REQ-010 O_Ld_FTk  output  FTk_t  load data token (v,a,r,c,i,d).
REQ-011 I_Ld_BTk  input  BTk_t  load back-token; .n = nack/stall.
REQ-012 I_St_Req  input  1  store request.
REQ-013 I_St_Addr  input  WIDTH_EXADDR  store address.
REQ-014 I_St_FTk  input  FTk_t  store data token.
REQ-015 O_St_BTk  output  BTk_t  store back-token; .n = store refused.
REQ-016 I_Host_We, I_Host_Addr (WIDTH_EXADDR), I_Host_Data (WIDTH_DATA)  input  host preload port.

Function
REQ-017 SHALL implement FSM IDLE, BOOT_HDR, BOOT_PROG, SERVE.
REQ-018 IDLE -> BOOT_HDR when I_Boot=1; SERVE -> BOOT_HDR when I_Boot=1 (restart); BOOT_* ignore I_Boot.
REQ-019 BOOT_HDR SHALL emit BOOT_HDR tokens v=1,d=0,i=0; a=1 only on first header word, else 0.
REQ-020 BOOT_PROG SHALL emit BOOT_LEN tokens v=1,a=0,i=0,d=mem[k], k=0..BOOT_LEN-1, then enter SERVE.
REQ-021 Boot word counter SHALL advance only when I_Ld_BTk.n=0; with n=1 O_Ld_FTk SHALL hold its value.
REQ-022 SERVE: I_Ld_Req=1 at edge t SHALL yield O_Ld_FTk.v=1, d=mem[addr] at t+1 (1-cycle latency); else v=0.
REQ-023 SERVE with I_Ld_BTk.n=1 SHALL hold O_Ld_FTk and not sample a new request.
REQ-024 I_Ld_Req during BOOT_* SHALL be dropped, not queued.
REQ-025 O_Ld_FTk.r and .c SHALL always be 0.
REQ-026 Store SHALL write mem[St_Addr]=I_St_FTk.d when I_St_Req & I_St_FTk.v & ~O_St_BTk.n, in any state.
REQ-027 O_St_BTk.n SHALL be combinationally 1 iff I_Host_We=1 (host write has priority), else 0; other BTk_t fields 0.
REQ-028 Host write SHALL update mem at the edge regardless of state.
REQ-029 Load and store/host write to the same address in one cycle SHALL return old data (read-before-write).

Reset
REQ-030 reset low SHALL force IDLE, counters 0, O_Ld_FTk all-zero; memory contents not cleared.
REQ-031 Reset asserted mid-boot or mid-serve SHALL abort immediately; no token issued until next I_Boot.

Configuration
REQ-032 With EXTEND_MEM_EN defined, SERVE tokens SHALL carry i=Ld_Addr (index compression); boot tokens keep i=0.
REQ-033 Without EXTEND_MEM_EN, O_Ld_FTk.i SHALL be constant 0.

Structure
REQ-034 FTk_t, BTk_t, WIDTH_DATA, WIDTH_EXADDR SHALL come from pkg_en; FSM state enum SHALL live in pkg_en.
REQ-035 Memory array SHALL be a sub-module ext_mem_ram (1 read, 1 write port, synchronous read).

Verification
REQ-036 Preload mem[0..4]=1..5, pulse I_Boot -> 8 tokens: 0(a=1),0,0,1,2,3,4,5 then SERVE.
REQ-037 I_Ld_BTk.n=1 for 3 cycles during 2nd program word -> word 2 held 4 cycles, no skipped/duplicated word.
REQ-038 SERVE, Ld_Req addr 0x7 (mem=0xAB) -> next cycle v=1,d=0xAB; EXTEND_MEM_EN build i=0x7.
REQ-039 Store addr 0x10 d=0x55 with Host_We=1 -> St_BTk.n=1, mem[0x10] unchanged; repeat with Host_We=0 -> mem[0x10]=0x55.
REQ-040 Ld and St same addr 0x20 same cycle (old 0x1, new 0x2) -> load returns 0x1, next load 0x2.
REQ-041 reset low during 3rd header word -> O_Ld_FTk=0 immediately, IDLE; re-boot emits full 8-token sequence.
